systolic_core_sequencer: RTL and testbench
==========================================

SYSTOLIC_CORE_SEQUENCER -- requirements
Module: systolic_core_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_N, default 8, giving the tile edge (the array is ARRAY_N x ARRAY_N PEs).
REQ-002 SHALL have parameter PIPE_LAT, default 1, giving the PE multiply-accumulate pipeline depth in cycles.
REQ-003 SHALL have derived widths STEP_W = clog2(2*ARRAY_N-1) and IDX_W = max(1, clog2(ARRAY_N)).
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 core_rst_in  in  1  synchronous core clear, one-cycle pulse from the tile controller.
REQ-007 start_in  in  1  level request; held high by the controller until it samples done_out.
REQ-008 done_out  out  1  one-cycle pulse marking tile result valid in the accumulators.
REQ-009 busy_out  out  1  high in FEED, DRAIN and DONE.
REQ-010 feed_valid_out  out  1  high while operands are being injected.
REQ-011 feed_step_out  out  STEP_W  wavefront index 0..2*ARRAY_N-2.
REQ-012 lane_en_out  out  ARRAY_N  per-lane inject enable; lane i drives A row i and B column i.
REQ-013 k_idx_out  out  ARRAY_N*IDX_W  packed per-lane operand index; lane i occupies bits [i*IDX_W +: IDX_W].
REQ-014 acc_clear_out  out  1  PE accumulator clear pulse.

Function
REQ-015 SHALL implement states IDLE, FEED, DRAIN, DONE and WAIT_LOW.
REQ-016 IDLE -> FEED on start_in=1; the step counter SHALL load 0.
REQ-017 FEED SHALL last exactly 2*ARRAY_N-1 cycles with feed_step_out = 0,1,...,2*ARRAY_N-2, then go to DRAIN.
REQ-018 In FEED, lane_en_out[i] SHALL be 1 iff i <= step <= i+ARRAY_N-1, and k_idx lane i SHALL be step-i; a disabled lane's k_idx SHALL be 0.
REQ-019 Outside FEED, feed_valid_out, lane_en_out, k_idx_out and feed_step_out SHALL be 0.
REQ-020 DRAIN SHALL last exactly ARRAY_N+PIPE_LAT cycles, then go to DONE.
REQ-021 DONE SHALL last one cycle with done_out=1; next state SHALL be IDLE if start_in=0, else WAIT_LOW.
REQ-022 WAIT_LOW SHALL go to IDLE when start_in=0; a start held high after done SHALL never retrigger.
REQ-023 Latency: done_out SHALL assert in the (3*ARRAY_N+PIPE_LAT)-th cycle after the edge where IDLE samples start_in=1.
REQ-024 acc_clear_out SHALL be registered: high for exactly the cycle following each cycle with core_rst_in=1.
REQ-025 core_rst_in=1 in any state SHALL force IDLE at the next edge, clear the counters, and suppress done_out.
REQ-026 core_rst_in=1 and start_in=1 in the same cycle: reset SHALL win; start SHALL be honoured only from the next cycle, if still high.
REQ-027 The step and drain counters SHALL saturate or reload and never wrap within a run; start_in SHALL be ignored in FEED, DRAIN and DONE.
REQ-028 start_in dropping mid-run SHALL NOT abort the run.

Reset
REQ-029 On rst, the state SHALL be IDLE, all counters 0, and every output 0, including done_out, busy_out and acc_clear_out.
REQ-030 On rst release, the first start SHALL require start_in sampled high in IDLE; no implicit run SHALL occur.

Structure
REQ-031 Package systolic_pkg SHALL hold the ARRAY_N/PIPE_LAT defaults, the state encoding constants, and the STEP_W/IDX_W width functions, shared with the controller and PE array.
REQ-032 SHALL contain one combinational sub-module seq_lane_decode (inputs step, lane index; outputs en, k_idx), instantiated ARRAY_N times.

Verification (ARRAY_N=4, PIPE_LAT=1)
REQ-033 Reset, then start_in high for one edge -> feed_step 0..6 over 7 cycles, 5 DRAIN cycles, done_out in cycle 13, start low -> IDLE.
REQ-034 Check the lane decode at step 3 -> lane_en=4'b1111 and k_idx lanes 0..3 = 3,2,1,0; at step 5 -> lane_en=4'b1100 and k lanes 2,3 = 3,2.
REQ-035 start_in held high 3 cycles past done -> WAIT_LOW, no second feed_valid, IDLE after start falls, second run completes normally.
REQ-036 core_rst_in pulse at step 2 of FEED -> IDLE next cycle, acc_clear_out one cycle, no done_out; a later start gives a full 13-cycle run.
REQ-037 core_rst_in and start_in high in the same cycle -> acc_clear_out pulse, no FEED that cycle; FEED begins one cycle after if start is still high.
REQ-038 Assert rst during DRAIN -> all outputs 0 immediately (async), state IDLE after release.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile: default geometry, sequencer state
// encoding and the width helpers used by the controller and PE array.
package systolic_pkg;

  localparam int ARRAY_N_DEF  = 8;
  localparam int PIPE_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FEED     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } seq_state_t;

  // Wavefront index width: holds 0..2*n-2.
  function automatic int step_w(input int n);
    return (2 * n - 1 > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Drain counter width: holds 0..n+p-1.
  function automatic int drain_w(input int n, input int p);
    return (n + p > 1) ? $clog2(n + p) : 1;
  endfunction

endpackage

// File: rtl/seq_lane_decode.sv
// Per-lane wavefront decode: a lane injects while the wavefront covers it and
// feeds operand index step-lane; disabled lanes report index 0.
module seq_lane_decode
  import systolic_pkg::*;
#(
  parameter  int ARRAY_N = ARRAY_N_DEF,
  localparam int STEP_W  = step_w(ARRAY_N),
  localparam int IDX_W   = idx_w(ARRAY_N)
) (
  input  logic [STEP_W-1:0] step_in,
  input  logic [IDX_W-1:0]  lane_in,
  output logic              en_out,
  output logic [IDX_W-1:0]  k_idx_out
);

  // One spare bit keeps the subtraction and range compare free of wrap.
  localparam int EW = STEP_W + 1;

  logic [EW-1:0] step_x;
  logic [EW-1:0] lane_x;
  logic [EW-1:0] diff;

  always_comb begin
    step_x    = EW'(step_in);
    lane_x    = EW'(lane_in);
    diff      = step_x - lane_x;
    en_out    = (step_x >= lane_x) && (diff <= EW'(ARRAY_N - 1));
    k_idx_out = en_out ? diff[IDX_W-1:0] : '0;
  end

endmodule

// File: rtl/systolic_core_sequencer.sv
// Tile sequencer: skews operands into the array over 2N-1 wavefront steps,
// waits for the PE pipeline to drain, then pulses done once per start request.
module systolic_core_sequencer
  import systolic_pkg::*;
#(
  parameter  int ARRAY_N  = ARRAY_N_DEF,
  parameter  int PIPE_LAT = PIPE_LAT_DEF,
  localparam int STEP_W   = step_w(ARRAY_N),
  localparam int IDX_W    = idx_w(ARRAY_N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_rst_in,
  input  logic                     start_in,
  output logic                     done_out,
  output logic                     busy_out,
  output logic                     feed_valid_out,
  output logic [STEP_W-1:0]        feed_step_out,
  output logic [ARRAY_N-1:0]       lane_en_out,
  output logic [ARRAY_N*IDX_W-1:0] k_idx_out,
  output logic                     acc_clear_out
);

  localparam int DRAIN_W = drain_w(ARRAY_N, PIPE_LAT);
  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(2 * ARRAY_N - 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ARRAY_N + PIPE_LAT - 1);

  seq_state_t         state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               acc_clear_q, acc_clear_d;

  logic [ARRAY_N-1:0]       lane_en_raw;
  logic [ARRAY_N*IDX_W-1:0] k_idx_raw;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      drain_q     <= '0;
      acc_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      drain_q     <= drain_d;
      acc_clear_q <= acc_clear_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    drain_d     = drain_q;
    acc_clear_d = core_rst_in;

    if (core_rst_in) begin
      state_d = ST_IDLE;
      step_d  = '0;
      drain_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            state_d = ST_FEED;
            step_d  = '0;
          end
        end
        ST_FEED: begin
          if (step_q == LAST_STEP) begin
            state_d = ST_DRAIN;
            step_d  = '0;
            drain_d = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = ST_DONE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = start_in ? ST_WAIT_LOW : ST_IDLE;
        end
        ST_WAIT_LOW: begin
          if (!start_in) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    seq_lane_decode #(.ARRAY_N(ARRAY_N)) u_dec (
      .step_in   (step_q),
      .lane_in   (IDX_W'(i)),
      .en_out    (lane_en_raw[i]),
      .k_idx_out (k_idx_raw[i*IDX_W +: IDX_W])
    );
  end

  always_comb begin
    feed_valid_out = (state_q == ST_FEED);
    busy_out       = (state_q == ST_FEED) || (state_q == ST_DRAIN) || (state_q == ST_DONE);
    done_out       = (state_q == ST_DONE);
    feed_step_out  = feed_valid_out ? step_q : '0;
    lane_en_out    = feed_valid_out ? lane_en_raw : '0;
    k_idx_out      = feed_valid_out ? k_idx_raw : '0;
    acc_clear_out  = acc_clear_q;
  end

endmodule

// File: tb/tb_systolic_core_sequencer.sv
// Scoreboard bench for the tile sequencer: a run-time reference model predicts
// each cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_systolic_core_sequencer;

  localparam int N       = 4;
  localparam int P       = 1;
  localparam int RUN_LEN = 3 * N + P;   // FEED + DRAIN + DONE cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       core_rst_in;
  logic       start_in;
  logic       done_out;
  logic       busy_out;
  logic       feed_valid_out;
  logic [2:0] feed_step_out;
  logic [3:0] lane_en_out;
  logic [7:0] k_idx_out;
  logic       acc_clear_out;

  systolic_core_sequencer #(.ARRAY_N(N), .PIPE_LAT(P)) dut (
    .clk            (clk),
    .rst            (rst),
    .core_rst_in    (core_rst_in),
    .start_in       (start_in),
    .done_out       (done_out),
    .busy_out       (busy_out),
    .feed_valid_out (feed_valid_out),
    .feed_step_out  (feed_step_out),
    .lane_en_out    (lane_en_out),
    .k_idx_out      (k_idx_out),
    .acc_clear_out  (acc_clear_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fv;
    logic [2:0] step;
    logic [3:0] en;
    logic [7:0] k;
    logic       busy;
    logic       done;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Expected outputs for cycle t of a run (t<0 means no run in progress).
  function automatic exp_t predict(input int t, input logic clr);
    exp_t e = '0;
    e.clr = clr;
    if (t >= 0) begin
      e.busy = 1'b1;
      e.done = (t == RUN_LEN - 1);
      if (t <= 2 * N - 2) begin
        e.fv   = 1'b1;
        e.step = t[2:0];
        for (int i = 0; i < N; i++) begin
          if (i <= t && t <= i + N - 1) begin
            e.en[i]        = 1'b1;
            e.k[i*2 +: 2]  = 2'(t - i);
          end
        end
      end
    end
    return e;
  endfunction

  // Reference model: tracks position within a run and whether a held start
  // must fall before another run may be accepted.
  initial begin
    int run_t   = -1;
    bit waiting = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        run_t   = -1;
        waiting = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);
      end else begin
        if (core_rst_in) begin
          run_t   = -1;
          waiting = 1'b0;
        end else if (run_t >= 0) begin
          if (run_t == RUN_LEN - 1) begin
            run_t   = -1;
            waiting = start_in;
          end else begin
            run_t++;
          end
        end else if (waiting) begin
          if (!start_in) waiting = 1'b0;
        end else if (start_in) begin
          run_t = 0;
        end
        exp_q.push_back(predict(run_t, core_rst_in));
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("feed_valid", 32'(feed_valid_out), 32'(e.fv));
        check("feed_step",  32'(feed_step_out),  32'(e.step));
        check("lane_en",    32'(lane_en_out),    32'(e.en));
        check("k_idx",      32'(k_idx_out),      32'(e.k));
        check("busy",       32'(busy_out),       32'(e.busy));
        check("done",       32'(done_out),       32'(e.done));
        check("acc_clear",  32'(acc_clear_out),  32'(e.clr));
        if (e.fv && e.step == 3'd3) begin
          check("step3_lane_en", 32'(lane_en_out), 32'h0000000F);
          check("step3_k_idx",   32'(k_idx_out),   32'h0000001B);
        end
        if (e.fv && e.step == 3'd5) begin
          check("step5_lane_en", 32'(lane_en_out),   32'h0000000C);
          check("step5_k_hi",    32'(k_idx_out[7:4]), 32'h0000000B);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    start_in    = 1'b0;
    core_rst_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Single-edge start, full run
    start_in = 1'b1; tick(); start_in = 1'b0;
    repeat (16) tick();

    // Start held past done, then a second run
    start_in = 1'b1;
    repeat (RUN_LEN + 3) tick();
    start_in = 1'b0;
    repeat (3) tick();
    start_in = 1'b1; tick(); start_in = 1'b0;
    repeat (16) tick();

    // Core clear at FEED step 2, then a full run
    start_in = 1'b1; tick(); start_in = 1'b0;
    tick(); tick();
    core_rst_in = 1'b1; tick(); core_rst_in = 1'b0;
    repeat (4) tick();
    start_in = 1'b1; tick(); start_in = 1'b0;
    repeat (16) tick();

    // Core clear and start together; start stays high one more cycle
    start_in = 1'b1; core_rst_in = 1'b1; tick();
    core_rst_in = 1'b0; tick();
    start_in = 1'b0;
    repeat (16) tick();

    // Asynchronous reset in DRAIN
    start_in = 1'b1; tick(); start_in = 1'b0;
    repeat (9) tick();
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();

    // Random start / core clear traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) start_in = ~start_in;
      core_rst_in = ($urandom_range(0, 39) == 0);
      tick();
    end
    start_in    = 1'b0;
    core_rst_in = 1'b0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
